// File: rtl/alu_issue_arbiter_if.sv
// Bundle of every signal the ALU issue arbiter exchanges with its two
// requesters, the shared ALU and the response consumer.
//
// Handshake rule for both requesters and the response port: a transfer
// happens on a rising CLK edge where valid and ready are both high. Only
// that edge is sampled. A requester may drop valid before ready appears.
// Ready is combinational, but it is only raised while the arbiter is idle.
//
// slave  : the arbiter itself.
// master : the environment, which includes the requesters, the ALU and the consumer.
interface alu_issue_arbiter_if #(
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_ready;
    logic [2:0]        req0_op;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;

    logic              req1_valid;
    logic              req1_ready;
    logic [2:0]        req1_op;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;

    logic              alu_active;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_in1;
    logic [DATA_W-1:0] alu_in2;
    logic [DATA_W-1:0] alu_data;
    logic              alu_zero;
    logic              alu_lt;
    logic              alu_gt;
    logic              alu_ovf;
    logic              alu_cout;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic [5:0]        rsp_flags;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output alu_active, alu_op, alu_in1, alu_in2,
        input  alu_data, alu_zero, alu_lt, alu_gt, alu_ovf, alu_cout,
        output rsp_valid, rsp_id, rsp_data, rsp_flags,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  alu_active, alu_op, alu_in1, alu_in2,
        output alu_data, alu_zero, alu_lt, alu_gt, alu_ovf, alu_cout,
        input  rsp_valid, rsp_id, rsp_data, rsp_flags,
        output rsp_ready
    );
endinterface

// File: rtl/alu_issue_arbiter.sv
// Round-robin arbiter that shares one ALU between the execute stage (req0)
// and the address/branch unit (req1). The arbiter keeps only one operation
// in flight at a time. It holds the operands on the ALU for SETTLE_CYCLES
// and then captures the result and the flags into a response register.
// A valid/ready handshake drains that register.
module alu_issue_arbiter #(
    parameter int DATA_W        = 16,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               CLK,
    input  logic               RST_N,
    alu_issue_arbiter_if.slave bus,
    output logic [1:0]         dbgState
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_LOAD   = 4'(SETTLE_CYCLES);
    localparam logic [2:0] OP_LAST_LEGAL = 3'b101;
    localparam logic [5:0] ERR_FLAGS     = 6'b100000;

    state_t            state;
    state_t            nextState;
    logic              lastGrant;
    logic              grantId;
    logic              anyValid;
    logic              accept;
    logic              legalOp;
    logic              req0Ready;
    logic              req1Ready;
    logic [2:0]        selOp;
    logic [DATA_W-1:0] selA;
    logic [DATA_W-1:0] selB;

    logic [2:0]        opReg;
    logic [DATA_W-1:0] aReg;
    logic [DATA_W-1:0] bReg;
    logic              idReg;
    logic [3:0]        settleCnt;
    logic [DATA_W-1:0] rspData;
    logic [5:0]        rspFlags;

    // Round-robin pick: a single requester always wins, a tie goes to the one not granted last
    always_comb begin
        grantId = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grantId = ~lastGrant;
        end else begin
            grantId = bus.req1_valid;
        end
    end

    assign anyValid = bus.req0_valid | bus.req1_valid;
    assign selOp    = grantId ? bus.req1_op : bus.req0_op;
    assign selA     = grantId ? bus.req1_a  : bus.req0_a;
    assign selB     = grantId ? bus.req1_b  : bus.req0_b;
    assign legalOp  = (selOp <= OP_LAST_LEGAL);

    // Next state and requester ready; grants only happen from IDLE
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        req0Ready = 1'b0;
        req1Ready = 1'b0;
        case (state)
            IDLE: begin
                if (anyValid) begin
                    accept    = 1'b1;
                    req0Ready = ~grantId;
                    req1Ready = grantId;
                    nextState = legalOp ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                if (settleCnt == 4'd1) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation or pending response
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Latch the granted operation, count the settle time, capture the ALU result
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lastGrant <= 1'b1;
            opReg     <= '0;
            aReg      <= '0;
            bReg      <= '0;
            idReg     <= 1'b0;
            settleCnt <= '0;
            rspData   <= '0;
            rspFlags  <= '0;
        end else begin
            if (accept) begin
                opReg     <= selOp;
                aReg      <= selA;
                bReg      <= selB;
                idReg     <= grantId;
                lastGrant <= grantId;
                settleCnt <= SETTLE_LOAD;
                if (!legalOp) begin
                    rspData  <= '0;
                    rspFlags <= ERR_FLAGS;
                end
            end
            if (state == ISSUE) begin
                settleCnt <= settleCnt - 4'd1;
                if (settleCnt == 4'd1) begin
                    rspData  <= bus.alu_data;
                    rspFlags <= {1'b0, bus.alu_cout, bus.alu_ovf, bus.alu_gt,
                                 bus.alu_lt, bus.alu_zero};
                end
            end
        end
    end

    // Operands and op stay on the ALU bus between issues; only alu_active gates the ALU
    assign bus.req0_ready = req0Ready;
    assign bus.req1_ready = req1Ready;
    assign bus.alu_active = (state == ISSUE);
    assign bus.alu_op     = opReg;
    assign bus.alu_in1    = aReg;
    assign bus.alu_in2    = bReg;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = idReg;
    assign bus.rsp_data   = rspData;
    assign bus.rsp_flags  = rspFlags;
    assign dbgState       = state;
endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter. The bench plays the role of the ALU. It runs a table of
// directed operations, hand-written arbitration, backpressure, illegal-op and
// reset sequences, and a random phase. A transaction-level reference model
// checks the outputs on every cycle.
module tb_alu_issue_arbiter;
    localparam int DATA_W = 16;
    localparam int SETTLE = 3;
    localparam int RW     = 1 + DATA_W + 6;

    logic       CLK   = 1'b0;
    logic       RST_N = 1'b0;
    logic [1:0] dbgState;

    alu_issue_arbiter_if #(.DATA_W(DATA_W)) bus();

    alu_issue_arbiter #(.DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .bus      (bus),
        .dbgState (dbgState)
    );

    // Clock
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behaviour of the shared ALU: returns {data, cout, ovf, gt, lt, zero}
    function automatic logic [DATA_W+4:0] aluRef(input logic [2:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [DATA_W:0]   wide;
        logic [DATA_W-1:0] r;
        logic              c;
        logic              v;
        wide = '0;
        r    = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (op)
            3'd0: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[DATA_W-1:0];
                c    = wide[DATA_W];
                v    = (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            end
            3'd1: begin
                wide = {1'b0, a} - {1'b0, b};
                r    = wide[DATA_W-1:0];
                c    = wide[DATA_W];
                v    = (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            3'd5: begin
                wide = {1'b0, a} + {1'b0, b};
                r    = wide[DATA_W-1:0];
                c    = wide[DATA_W];
                v    = c;
            end
            default: r = '0;
        endcase
        return {r, c, v, $signed(a) > $signed(b), $signed(a) < $signed(b), r == '0};
    endfunction

    // Expected response record {id, data, flags}
    function automatic logic [RW-1:0] expRsp(input logic id, input logic [2:0] op,
                                             input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
        logic [DATA_W+4:0] res;
        res = aluRef(op, a, b);
        if (op > 3'd5) return {id, {DATA_W{1'b0}}, 6'b100000};
        return {id, res[DATA_W+4:5], 1'b0, res[4:0]};
    endfunction

    // ALU stand-in; drives a recognisable junk pattern while it is not enabled
    assign {bus.alu_data, bus.alu_cout, bus.alu_ovf, bus.alu_gt, bus.alu_lt, bus.alu_zero} =
        bus.alu_active ? aluRef(bus.alu_op, bus.alu_in1, bus.alu_in2)
                       : {16'hDEAD, 5'b10101};

    // Reference model: one operation outstanding, countdown until the result is due
    function automatic int modelGrant(input logic v0, input logic v1, input bit last);
        if (v0 && v1) return last ? 0 : 1;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    bit                mBusy = 1'b0;
    int                mLeft = 0;
    bit                mLast = 1'b1;
    int                mG;
    int                mG2;
    logic [2:0]        mOp;
    logic [DATA_W-1:0] mA;
    logic [DATA_W-1:0] mB;
    logic [RW-1:0]     exp_q[$];
    bit                chkOn = 1'b0;
    bit                sawActive = 1'b0;

    // Model update at each clock edge, cleared by reset
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mBusy = 1'b0;
            mLeft = 0;
            mLast = 1'b1;
            exp_q.delete();
        end else if (!mBusy) begin
            mG = modelGrant(bus.req0_valid, bus.req1_valid, mLast);
            if (mG >= 0) begin
                mLast = mG[0];
                mBusy = 1'b1;
                if (mG == 0) begin
                    mOp = bus.req0_op; mA = bus.req0_a; mB = bus.req0_b;
                end else begin
                    mOp = bus.req1_op; mA = bus.req1_a; mB = bus.req1_b;
                end
                mLeft = (mOp <= 3'd5) ? SETTLE : 0;
                exp_q.push_back(expRsp(mG[0], mOp, mA, mB));
            end
        end else if (mLeft > 0) begin
            mLeft--;
        end else if (bus.rsp_ready) begin
            mBusy = 1'b0;
            void'(exp_q.pop_front());
        end
    end

    always @(posedge CLK) if (bus.alu_active === 1'b1) sawActive = 1'b1;

    // Scoreboard: compare every output against the model, late in each cycle
    always @(negedge CLK) begin
        #2;
        if (RST_N && chkOn) begin
            mG2 = mBusy ? -1 : modelGrant(bus.req0_valid, bus.req1_valid, mLast);
            chk("req0_ready", 32'(bus.req0_ready), 32'(mG2 == 0));
            chk("req1_ready", 32'(bus.req1_ready), 32'(mG2 == 1));
            chk("alu_active", 32'(bus.alu_active), 32'(mBusy && mLeft > 0));
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(mBusy && mLeft == 0));
            if (mBusy && mLeft > 0) begin
                chk("alu_op", 32'(bus.alu_op), 32'(mOp));
                chk("alu_in1", 32'(bus.alu_in1), 32'(mA));
                chk("alu_in2", 32'(bus.alu_in2), 32'(mB));
            end
            if (mBusy && mLeft == 0) begin
                chk("exp_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    chk("rsp_record", 32'({bus.rsp_id, bus.rsp_data, bus.rsp_flags}),
                        32'(exp_q[0]));
                end
            end
        end
    end

    // Driver tasks
    function automatic logic rdy(input bit id);
        return id ? bus.req1_ready : bus.req0_ready;
    endfunction

    task automatic setReq(input bit id, input logic v, input logic [2:0] op,
                          input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (id) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    task automatic applyReset();
        @(negedge CLK);
        RST_N = 1'b0;
        setReq(1'b0, 1'b0, 3'd0, '0, '0);
        setReq(1'b1, 1'b0, 3'd0, '0, '0);
        bus.rsp_ready = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
    endtask

    task automatic waitReady(input bit id, input string name);
        int n;
        n = 0;
        #1;
        while (rdy(id) !== 1'b1 && n < 20) begin
            @(negedge CLK);
            #1;
            n++;
        end
        chk(name, 32'(n < 20), 32'd1);
    endtask

    task automatic waitRsp(output int lat);
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        repeat (SETTLE + 4) @(negedge CLK);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_req0_ready"}, 32'(bus.req0_ready), 32'd0);
        chk({tag, "_req1_ready"}, 32'(bus.req1_ready), 32'd0);
        chk({tag, "_alu_active"}, 32'(bus.alu_active), 32'd0);
        chk({tag, "_alu_op"}, 32'(bus.alu_op), 32'd0);
        chk({tag, "_alu_in1"}, 32'(bus.alu_in1), 32'd0);
        chk({tag, "_alu_in2"}, 32'(bus.alu_in2), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_id"}, 32'(bus.rsp_id), 32'd0);
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
        chk({tag, "_rsp_flags"}, 32'(bus.rsp_flags), 32'd0);
    endtask

    typedef struct {
        bit                id;
        logic [2:0]        op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] data;
        logic [5:0]        flags;
    } vec_t;

    vec_t vecs[9];

    task automatic runVec(input vec_t v);
        int lat;
        @(negedge CLK);
        setReq(v.id, 1'b1, v.op, v.a, v.b);
        waitReady(v.id, "vec_grant");
        @(posedge CLK);
        @(negedge CLK);
        setReq(v.id, 1'b0, 3'd0, '0, '0);
        waitRsp(lat);
        chk("vec_latency", 32'(lat), (v.op > 3'd5) ? 32'd0 : 32'(SETTLE));
        chk("vec_rsp_data", 32'(bus.rsp_data), 32'(v.data));
        chk("vec_rsp_flags", 32'(bus.rsp_flags), 32'(v.flags));
        chk("vec_rsp_id", 32'(bus.rsp_id), 32'(v.id));
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        bus.rsp_ready = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return DATA_W'($urandom);
        endcase
    endfunction

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        int lat;
        setReq(1'b0, 1'b0, 3'd0, '0, '0);
        setReq(1'b1, 1'b0, 3'd0, '0, '0);
        bus.rsp_ready = 1'b0;

        vecs[0] = '{1'b0, 3'd0, 16'h4491, 16'h44B1, 16'h8942, 6'b001010};
        vecs[1] = '{1'b1, 3'd4, 16'h0491, 16'h04B1, 16'h0001, 6'b000010};
        vecs[2] = '{1'b0, 3'd2, 16'h0491, 16'h04B1, 16'h0491, 6'b000010};
        vecs[3] = '{1'b1, 3'd3, 16'h0491, 16'h04B1, 16'h04B1, 6'b000010};
        vecs[4] = '{1'b0, 3'd1, 16'h0005, 16'h0005, 16'h0000, 6'b000001};
        vecs[5] = '{1'b1, 3'd1, 16'h0001, 16'h0002, 16'hFFFF, 6'b010010};
        vecs[6] = '{1'b0, 3'd5, 16'hFFFF, 16'h0001, 16'h0000, 6'b011011};
        vecs[7] = '{1'b1, 3'd0, 16'h7FFF, 16'h0001, 16'h8000, 6'b001100};
        vecs[8] = '{1'b1, 3'd7, 16'h1234, 16'h5678, 16'h0000, 6'b100000};

        // Reset state
        applyReset();
        #1;
        checkAllZero("reset");
        chk("reset_dbg_state", 32'(dbgState), 32'd0);
        chkOn = 1'b1;

        // Directed table
        for (int i = 0; i < 9; i++) runVec(vecs[i]);

        // Simultaneous requests after reset alternate, req0 first
        applyReset();
        @(negedge CLK);
        setReq(1'b0, 1'b1, 3'd2, 16'h0491, 16'h04B1);
        setReq(1'b1, 1'b1, 3'd3, 16'h0491, 16'h04B1);
        bus.rsp_ready = 1'b1;
        #1;
        chk("rr_first_req0", 32'(bus.req0_ready), 32'd1);
        chk("rr_first_req1", 32'(bus.req1_ready), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        setReq(1'b0, 1'b0, 3'd0, '0, '0);
        waitReady(1'b1, "rr_second_req1");
        @(posedge CLK);
        @(negedge CLK);
        setReq(1'b0, 1'b1, 3'd2, 16'h0491, 16'h04B1);
        #1;
        while (!(bus.req0_ready || bus.req1_ready) && !(dbgState == 2'd3)) begin
            @(negedge CLK);
            #1;
            if (bus.req0_ready || bus.req1_ready || bus.rsp_valid === 1'bx) break;
            if (mBusy == 1'b0) break;
        end
        chk("rr_third_req0", 32'(bus.req0_ready), 32'd1);
        chk("rr_third_req1", 32'(bus.req1_ready), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        setReq(1'b0, 1'b0, 3'd0, '0, '0);
        setReq(1'b1, 1'b0, 3'd0, '0, '0);
        drain();

        // Response held under backpressure, then next grant one cycle after the drain
        @(negedge CLK);
        setReq(1'b1, 1'b1, 3'd1, 16'h0001, 16'h0002);
        waitReady(1'b1, "bp_grant");
        @(posedge CLK);
        @(negedge CLK);
        setReq(1'b1, 1'b0, 3'd0, '0, '0);
        waitRsp(lat);
        chk("bp_latency", 32'(lat), 32'(SETTLE));
        setReq(1'b0, 1'b1, 3'd0, 16'h0003, 16'h0004);
        setReq(1'b1, 1'b1, 3'd0, 16'h0005, 16'h0006);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_data", 32'(bus.rsp_data), 32'h0000FFFF);
            chk("bp_rsp_flags", 32'(bus.rsp_flags), 32'b010010);
            chk("bp_rsp_id", 32'(bus.rsp_id), 32'd1);
            chk("bp_req0_ready", 32'(bus.req0_ready), 32'd0);
            chk("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
            @(negedge CLK);
        end
        bus.rsp_ready = 1'b1;
        @(negedge CLK);
        bus.rsp_ready = 1'b0;
        #1;
        chk("bp_next_req0", 32'(bus.req0_ready), 32'd1);
        chk("bp_next_req1", 32'(bus.req1_ready), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        setReq(1'b0, 1'b0, 3'd0, '0, '0);
        setReq(1'b1, 1'b0, 3'd0, '0, '0);
        drain();

        // Illegal op never enables the ALU
        @(negedge CLK);
        sawActive = 1'b0;
        runVec('{1'b0, 3'd6, 16'hAAAA, 16'h5555, 16'h0000, 6'b100000});
        chk("illegal_alu_active", 32'(sawActive), 32'd0);

        // Asynchronous reset in the middle of ISSUE
        applyReset();
        @(negedge CLK);
        setReq(1'b1, 1'b1, 3'd1, 16'h1234, 16'h0F0F);
        waitReady(1'b1, "rst_grant");
        @(posedge CLK);
        @(negedge CLK);
        setReq(1'b1, 1'b0, 3'd0, '0, '0);
        @(posedge CLK);
        #2;
        chk("rst_in_issue", 32'(bus.alu_active), 32'd1);
        RST_N = 1'b0;
        #1;
        checkAllZero("midrst");
        @(negedge CLK);
        RST_N = 1'b1;
        setReq(1'b0, 1'b1, 3'd3, 16'h00F0, 16'h0F00);
        setReq(1'b1, 1'b1, 3'd2, 16'h00F0, 16'h0F00);
        #1;
        chk("rst_after_req0", 32'(bus.req0_ready), 32'd1);
        chk("rst_after_req1", 32'(bus.req1_ready), 32'd0);
        @(posedge CLK);
        @(negedge CLK);
        setReq(1'b0, 1'b0, 3'd0, '0, '0);
        setReq(1'b1, 1'b0, 3'd0, '0, '0);
        drain();

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            setReq(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   pickOperand(), pickOperand());
            setReq(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   pickOperand(), pickOperand());
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge CLK);
        setReq(1'b0, 1'b0, 3'd0, '0, '0);
        setReq(1'b1, 1'b0, 3'd0, '0, '0);
        drain();
        @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
